// File: rtl/cdr_frame_deframer_if.sv
// Bundle of the CDR-side bit stream, control strobes and CPU-side FIFO read
// port of the frame deframer. The master side is the CDR/CPU environment,
// the slave side is the deframer itself.
interface cdr_frame_deframer_if #(
  parameter int FIFO_SIZE_BIT = 4
);
  logic                   i_data;
  logic                   i_flag;
  logic                   i_flush;
  logic                   i_clear;
  logic                   i_rd_en;
  logic [7:0]             o_data;
  logic                   o_rd_valid;
  logic [FIFO_SIZE_BIT:0] o_count;
  logic                   o_full;
  logic                   o_empty;
  logic                   o_almost_full;
  logic                   o_rd_error;
  logic                   o_overflow;
  logic                   o_frame_done;
  logic                   o_frame_err;
  logic                   o_len_error;
  logic                   o_busy;

  modport master (
    output i_data, i_flag, i_flush, i_clear, i_rd_en,
    input  o_data, o_rd_valid, o_count, o_full, o_empty, o_almost_full,
           o_rd_error, o_overflow, o_frame_done, o_frame_err, o_len_error, o_busy
  );

  modport slave (
    input  i_data, i_flag, i_flush, i_clear, i_rd_en,
    output o_data, o_rd_valid, o_count, o_full, o_empty, o_almost_full,
           o_rd_error, o_overflow, o_frame_done, o_frame_err, o_len_error, o_busy
  );
endinterface

// File: rtl/cdr_frame_deframer.sv
// 802.15.4 frame deframer: hunts for the SFD in the CDR bit stream, checks the
// PHR length, assembles payload bytes and buffers length + payload in a FIFO.
// A completed byte is staged for one cycle and written on the following edge.
module cdr_frame_deframer #(
  parameter int         FIFO_SIZE_BIT = 4,
  parameter logic [7:0] SFD_PATTERN   = 8'hA7,
  parameter int         MAX_LEN       = 127,
  parameter bit         MSB_FIRST     = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cdr_frame_deframer_if.slave  bus
);
  localparam int DEPTH = 1 << FIFO_SIZE_BIT;
  localparam logic [FIFO_SIZE_BIT:0]   DEPTH_C  = (FIFO_SIZE_BIT+1)'(DEPTH);
  localparam logic [FIFO_SIZE_BIT:0]   AFULL_C  = (FIFO_SIZE_BIT+1)'(DEPTH - 2);
  localparam logic [FIFO_SIZE_BIT:0]   CNT_ONE  = (FIFO_SIZE_BIT+1)'(1);
  localparam logic [FIFO_SIZE_BIT-1:0] PTR_ONE  = FIFO_SIZE_BIT'(1);
  localparam logic [6:0]               MAXLEN_C = 7'(MAX_LEN);

  typedef enum logic [1:0] {ST_HUNT = 2'd0, ST_LEN = 2'd1, ST_DATA = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [7:0]               sr_q, sr_d, sr_shift_s;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [6:0]               byte_cnt_q, byte_cnt_d;
  logic                     wr_pend_q, wr_pend_d;
  logic [7:0]               wr_byte_q, wr_byte_d;
  logic                     last_q, last_d;
  logic                     len_pend_q, len_pend_d;
  logic                     sfd_hit_s;
  logic                     frm_err_q, frm_err_d;
  logic [7:0]               mem_q [DEPTH];
  logic [FIFO_SIZE_BIT-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_SIZE_BIT:0]   count_q, count_d;
  logic                     rd_ok_s, wr_ok_s, drop_s;
  logic [7:0]               data_q;
  logic                     rd_valid_q, rd_error_q, full_q, empty_q, afull_q, ovf_q;
  logic                     frame_done_q, frame_err_q, len_error_q, busy_q;
  logic                     frame_done_d;

  assign sr_shift_s = MSB_FIRST ? {sr_q[6:0], bus.i_data} : {bus.i_data, sr_q[7:1]};

  // Framing FSM next state: SFD hunt, PHR length check, payload byte assembly.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    wr_pend_d  = 1'b0;
    wr_byte_d  = wr_byte_q;
    last_d     = 1'b0;
    len_pend_d = 1'b0;
    sfd_hit_s  = 1'b0;
    if (bus.i_flush) begin
      state_d   = ST_HUNT;
      bit_cnt_d = 3'd0;
    end else if (bus.i_flag) begin
      sr_d = sr_shift_s;
      case (state_q)
        ST_HUNT: begin
          if (sr_shift_s == SFD_PATTERN) begin
            state_d   = ST_LEN;
            bit_cnt_d = 3'd0;
            sfd_hit_s = 1'b1;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LEN: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if ((sr_shift_s[6:0] == 7'd0) || (sr_shift_s[6:0] > MAXLEN_C)) begin
              len_pend_d = 1'b1;
              state_d    = ST_HUNT;
            end else begin
              wr_pend_d  = 1'b1;
              wr_byte_d  = sr_shift_s;
              byte_cnt_d = sr_shift_s[6:0];
              state_d    = ST_DATA;
            end
          end else begin
            state_d = ST_LEN;
          end
        end
        ST_DATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wr_pend_d  = 1'b1;
            wr_byte_d  = sr_shift_s;
            byte_cnt_d = byte_cnt_q - 7'd1;
            if (byte_cnt_q == 7'd1) begin
              last_d  = 1'b1;
              state_d = ST_HUNT;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end else begin
      sr_d = sr_q;
    end
  end

  // FIFO handshake: a full FIFO still accepts a write if a read frees a slot.
  always_comb begin
    rd_ok_s = bus.i_rd_en && !empty_q;
    wr_ok_s = wr_pend_q && (!full_q || rd_ok_s);
    drop_s  = wr_pend_q && full_q && !rd_ok_s;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    frame_done_d = last_q && !bus.i_flush;
    if (bus.i_flush || sfd_hit_s) begin
      frm_err_d = 1'b0;
    end else if (drop_s) begin
      frm_err_d = 1'b1;
    end else begin
      frm_err_d = frm_err_q;
    end
  end

  // Framing state, shift register, counters and the one-cycle write stage.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_HUNT;
      sr_q       <= 8'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 7'd0;
      wr_pend_q  <= 1'b0;
      wr_byte_q  <= 8'd0;
      last_q     <= 1'b0;
      len_pend_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      wr_pend_q  <= wr_pend_d;
      wr_byte_q  <= wr_byte_d;
      last_q     <= last_d;
      len_pend_q <= len_pend_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // FIFO storage array; no reset needed, occupancy tracks validity.
  always_ff @(posedge i_clk) begin
    if (wr_ok_s) mem_q[wr_ptr_q] <= wr_byte_q;
  end

  // FIFO pointers, read port, status flags and event pulses.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_q       <= 8'd0;
      rd_valid_q   <= 1'b0;
      rd_error_q   <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= 1'b0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      len_error_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (wr_ok_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        data_q   <= mem_q[rd_ptr_q];
      end
      count_q      <= count_d;
      rd_valid_q   <= rd_ok_s;
      rd_error_q   <= bus.i_rd_en && empty_q;
      full_q       <= (count_d == DEPTH_C);
      empty_q      <= (count_d == '0);
      afull_q      <= (count_d >= AFULL_C);
      ovf_q        <= drop_s ? 1'b1 : (bus.i_clear ? 1'b0 : ovf_q);
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_done_d && (frm_err_q || drop_s);
      len_error_q  <= len_pend_q;
      busy_q       <= (state_d != ST_HUNT);
    end
  end

  assign bus.o_data        = data_q;
  assign bus.o_rd_valid    = rd_valid_q;
  assign bus.o_count       = count_q;
  assign bus.o_full        = full_q;
  assign bus.o_empty       = empty_q;
  assign bus.o_almost_full = afull_q;
  assign bus.o_rd_error    = rd_error_q;
  assign bus.o_overflow    = ovf_q;
  assign bus.o_frame_done  = frame_done_q;
  assign bus.o_frame_err   = frame_err_q;
  assign bus.o_len_error   = len_error_q;
  assign bus.o_busy        = busy_q;
endmodule
